// File: rtl/pwm_capture.sv
// +----------------------------------------------------------------------------+
// | pwm_capture: measures high time and period of an asynchronous PWM input,   |
// | with stuck-high/stuck-low timeout reporting under PWM_CAPTURE_TIMEOUT_EN.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module pwm_capture #(
  parameter int PWM_INTERVAL = 1200,
  parameter int TIMEOUT      = 2 * PWM_INTERVAL,
  localparam int CW          = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pwm_in,
  output logic [CW-1:0] duty,
  output logic [CW-1:0] period,
  output logic          valid,
  output logic          stuck_high,
  output logic          stuck_low
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic [CW-1:0] ONE         = CW'(1);
  localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);
  localparam logic [CW-1:0] TIMEOUT_M1  = CW'(TIMEOUT - 1);
`ifdef PWM_CAPTURE_TIMEOUT_EN
  localparam logic [CW-1:0] INTERVAL_CNT = CW'(PWM_INTERVAL);
`endif

  state_t        state_q, state_d;
  logic          s1_q, s2_q, s3_q;
  logic [CW-1:0] period_cnt_q, period_cnt_d;
  logic [CW-1:0] high_cnt_q, high_cnt_d;
  logic [CW-1:0] duty_q, duty_d;
  logic [CW-1:0] period_q, period_d;
  logic          valid_q, valid_d;
  logic          rise;
  logic          timeout;

  assign rise    = s2_q & ~s3_q;
  // Timeout fires only on the step into TIMEOUT; the held count cannot retrigger it.
  assign timeout = ~rise && (period_cnt_q == TIMEOUT_M1);

`ifdef PWM_CAPTURE_TIMEOUT_EN
  logic stuck_high_q, stuck_high_d;
  logic stuck_low_q, stuck_low_d;
`endif

  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    duty_d       = duty_q;
    period_d     = period_q;
    valid_d      = 1'b0;
`ifdef PWM_CAPTURE_TIMEOUT_EN
    stuck_high_d = stuck_high_q;
    stuck_low_d  = stuck_low_q;
`endif
    if (rise) begin
      state_d      = MEASURE;
      period_cnt_d = ONE;
      high_cnt_d   = ONE;
      if (state_q == MEASURE) begin
        duty_d   = high_cnt_q;
        period_d = period_cnt_q;
        valid_d  = 1'b1;
      end
`ifdef PWM_CAPTURE_TIMEOUT_EN
      stuck_high_d = 1'b0;
      stuck_low_d  = 1'b0;
`endif
    end else begin
      if (period_cnt_q != TIMEOUT_CNT) begin
        period_cnt_d = period_cnt_q + ONE;
      end
      if ((state_q == MEASURE) && s2_q && (high_cnt_q != TIMEOUT_CNT)) begin
        high_cnt_d = high_cnt_q + ONE;
      end
      if (timeout) begin
        state_d = IDLE;
`ifdef PWM_CAPTURE_TIMEOUT_EN
        duty_d       = s2_q ? INTERVAL_CNT : '0;
        period_d     = INTERVAL_CNT;
        valid_d      = 1'b1;
        stuck_high_d = s2_q;
        stuck_low_d  = ~s2_q;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      duty_q       <= '0;
      period_q     <= '0;
      valid_q      <= 1'b0;
`ifdef PWM_CAPTURE_TIMEOUT_EN
      stuck_high_q <= 1'b0;
      stuck_low_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      s1_q         <= pwm_in;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      duty_q       <= duty_d;
      period_q     <= period_d;
      valid_q      <= valid_d;
`ifdef PWM_CAPTURE_TIMEOUT_EN
      stuck_high_q <= stuck_high_d;
      stuck_low_q  <= stuck_low_d;
`endif
    end
  end

  assign duty   = duty_q;
  assign period = period_q;
  assign valid  = valid_q;
`ifdef PWM_CAPTURE_TIMEOUT_EN
  assign stuck_high = stuck_high_q;
  assign stuck_low  = stuck_low_q;
`else
  assign stuck_high = 1'b0;
  assign stuck_low  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pwm_capture.sv
// +----------------------------------------------------------------------------+
// | tb_pwm_capture: scoreboard bench for pwm_capture; expectations follow      |
// | PWM_CAPTURE_TIMEOUT_EN when it is defined. Revision: 1.0                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pwm_capture;

  localparam int PWM_INTERVAL = 1200;
  localparam int TIMEOUT      = 2 * PWM_INTERVAL;
  localparam int CW           = $clog2(TIMEOUT + 1);
`ifdef PWM_CAPTURE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk    = 1'b0;
  logic          reset  = 1'b1;
  logic          pwm_in = 1'b0;
  logic [CW-1:0] duty;
  logic [CW-1:0] period;
  logic          valid;
  logic          stuck_high;
  logic          stuck_low;

  pwm_capture #(
    .PWM_INTERVAL(PWM_INTERVAL),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pwm_in    (pwm_in),
    .duty      (duty),
    .period    (period),
    .valid     (valid),
    .stuck_high(stuck_high),
    .stuck_low (stuck_low)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int duty;
    int period;
    bit sh;
    bit sl;
    int at;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("valid_cycle", cyc, e.at);
        chk("duty", int'(duty), e.duty);
        chk("period", int'(period), e.period);
        chk("stuck_high", int'(stuck_high), int'(e.sh));
        chk("stuck_low", int'(stuck_low), int'(e.sl));
      end
    end
  end

  // One PWM period starting with a rise; the rise publishes the previous period.
  task automatic wave(input int hi, input int lo, input bit expv, input int ed, input int ep);
    if (expv) sb.push_back(exp_t'{ed, ep, 1'b0, 1'b0, cyc + 3});
    pwm_in = 1'b1;
    repeat (hi) @(negedge clk);
    pwm_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_duty"}, int'(duty), 0);
    chk({tag, "_period"}, int'(period), 0);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_stuck_high"}, int'(stuck_high), 0);
    chk({tag, "_stuck_low"}, int'(stuck_low), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");

    // Input stuck low from reset release
    reset = 1'b0;
    if (TO_EN) sb.push_back(exp_t'{0, PWM_INTERVAL, 1'b0, 1'b1, cyc + TIMEOUT});
    repeat (3000) @(negedge clk);
    chk("stuck_low_set", int'(stuck_low), int'(TO_EN));
    chk("stuck_high_idle", int'(stuck_high), 0);

    // First rise after timeout: no valid, flags clear
    pwm_in = 1'b1;
    repeat (4) @(negedge clk);
    chk("stuck_low_clear", int'(stuck_low), 0);
    repeat (296) @(negedge clk);
    pwm_in = 1'b0;
    repeat (900) @(negedge clk);
    repeat (4) wave(300, 900, 1'b1, 300, 1200);

    // Reset at cycle 500 of a period
    sb.push_back(exp_t'{300, 1200, 1'b0, 1'b0, cyc + 3});
    pwm_in = 1'b1;
    repeat (300) @(negedge clk);
    pwm_in = 1'b0;
    repeat (200) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk_zero("midreset");
    reset = 1'b0;
    repeat (696) @(negedge clk);
    wave(300, 900, 1'b0, 0, 0);
    wave(300, 900, 1'b1, 300, 1200);

    // Single-cycle pulses
    wave(1, 1199, 1'b1, 300, 1200);
    wave(1, 1199, 1'b1, 1, 1200);
    wave(1, 1199, 1'b1, 1, 1200);

    // Longest period that still measures (TIMEOUT-1)
    wave(100, 2299, 1'b1, 1, 1200);
    wave(100, 2299, 1'b1, 100, 2399);
    wave(600, 600, 1'b1, 100, 2399);
    wave(600, 600, 1'b1, 600, 1200);

    // Input stuck high for 5000 cycles
    sb.push_back(exp_t'{600, 1200, 1'b0, 1'b0, cyc + 3});
    if (TO_EN) sb.push_back(exp_t'{PWM_INTERVAL, PWM_INTERVAL, 1'b1, 1'b0, cyc + TIMEOUT + 2});
    pwm_in = 1'b1;
    repeat (5000) @(negedge clk);
    chk("stuck_high_set", int'(stuck_high), int'(TO_EN));
    chk("stuck_low_during_high", int'(stuck_low), 0);
    pwm_in = 1'b0;
    repeat (600) @(negedge clk);
    pwm_in = 1'b1;
    repeat (4) @(negedge clk);
    chk("stuck_high_clear", int'(stuck_high), 0);
    repeat (596) @(negedge clk);
    pwm_in = 1'b0;
    repeat (600) @(negedge clk);
    wave(600, 600, 1'b1, 600, 1200);

    repeat (20) @(negedge clk);
    chk("pending_valids", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 The block SHALL have parameter PWM_INTERVAL, default 1200, giving the nominal PWM period in clk cycles.
REQ-002 The block SHALL have parameter TIMEOUT, default 2*PWM_INTERVAL, giving the number of cycles without a rising edge before the input counts as stuck.
REQ-003 The block SHALL define the local width CW = $clog2(TIMEOUT+1) for all count outputs.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port pwm_in, input, 1 bit: asynchronous PWM signal to be measured, active-high.
REQ-007 The block SHALL have port duty, output, CW bits: high-time count of the last complete period.
REQ-008 The block SHALL have port period, output, CW bits: length in cycles of the last complete period.
REQ-009 The block SHALL have port valid, output, 1 bit: one-cycle pulse when duty and period update.
REQ-010 The block SHALL have port stuck_high, output, 1 bit: input held high for at least TIMEOUT cycles.
REQ-011 The block SHALL have port stuck_low, output, 1 bit: input held low for at least TIMEOUT cycles.

Function
REQ-012 pwm_in SHALL pass through a 2-flop synchronizer (s1, s2) plus a history flop s3; rise = s2 & ~s3.
REQ-013 The FSM SHALL have two states: IDLE, with no complete period seen, and MEASURE, with at least one rise seen.
REQ-014 In IDLE, on rise: go to MEASURE, set period_cnt=1 and high_cnt=1, and do not assert valid.
REQ-015 In MEASURE, on rise: duty<=high_cnt, period<=period_cnt, valid<=1, period_cnt<=1, high_cnt<=1, all on the same edge.
REQ-016 In MEASURE, on no rise: period_cnt+=1 (saturating at TIMEOUT), and high_cnt+=s2 (saturating at TIMEOUT).
REQ-017 valid SHALL assert in the cycle following the third rising clk edge after pwm_in rises, for exactly one cycle.
REQ-018 A 1-cycle-high pulse SHALL measure duty=1, and a 100% high input never rises and is handled by REQ-021.
REQ-019 period_cnt SHALL also count in IDLE, from reset, so a stuck input is detected without any edge.
REQ-020 Timeout is the single cycle in which period_cnt increments from TIMEOUT-1 to TIMEOUT with no rise, and the counter then holds at TIMEOUT until a rise.
REQ-021 On timeout the FSM SHALL return to IDLE, and the next rise follows REQ-014.
REQ-022 duty, period and the stuck flags SHALL hold their values between valid pulses.
REQ-023 duty SHALL never exceed period in any published pair.

Reset
REQ-024 While reset=1 at a clk edge: state=IDLE; s1, s2, s3, period_cnt, high_cnt, duty, period, valid, stuck_high and stuck_low all become 0.
REQ-025 Reset asserted mid-period SHALL discard the partial measurement, and the first rise after release produces no valid.
REQ-026 Reset SHALL take priority over rise and timeout in the same cycle.

Configuration
REQ-027 With PWM_CAPTURE_TIMEOUT_EN defined, on timeout: duty<=(s2 ? PWM_INTERVAL : 0), period<=PWM_INTERVAL, valid pulses once, and stuck_high<=s2, stuck_low<=~s2.
REQ-028 With PWM_CAPTURE_TIMEOUT_EN defined, both stuck flags SHALL clear on the next rise, on the same edge as REQ-014.
REQ-029 Without PWM_CAPTURE_TIMEOUT_EN, timeout SHALL only perform REQ-021 with no valid pulse and duty/period unchanged, and stuck_high/stuck_low SHALL be constant 0.

Verification
REQ-030 PWM_INTERVAL=1200, pwm_in 300 high / 900 low repeating -> first rise gives no valid, then valid every 1200 cycles with duty=300, period=1200.
REQ-031 Same bench, check latency -> valid is high exactly in the cycle after the 3rd clk edge following each pwm_in rise, and low at all other times.
REQ-032 pwm_in held 0 from reset, with the macro defined -> at cycle 2400, a single valid with duty=0, period=1200, stuck_low=1; no further valid; the flag clears on the next rise; without the macro -> no valid and the flags stay 0.
REQ-033 pwm_in held 1 for 5000 cycles after steady 600/1200 operation, with the macro defined -> a single valid with duty=1200, stuck_high=1; the next 600/1200 train yields duty=600 on the second rise.
REQ-034 reset pulsed at cycle 500 of a 1200-cycle period -> outputs all 0, no valid on the first rise after release, correct duty/period one period later.
REQ-035 1-cycle-high, 1200-cycle-period input -> duty=1, period=1200 on each valid.
